// File: rtl/mac_accum_pkg.sv
// Shared types and default widths for the MAC accumulate sequencer.
package mac_accum_pkg;
  localparam int DATA_WIDTH_DEF = 24;
  localparam int VEC_LENGTH_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int BEAT_W_DEF     = 8;
  localparam int PIPE_STAGES    = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [VEC_LENGTH_DEF-1:0][DATA_WIDTH_DEF-1:0] lane_vec_t;
endpackage

// File: rtl/mac_accum_sequencer_if.sv
// Command, beat, datapath and result signals of the sequencer; slave = sequencer side.
interface mac_accum_sequencer_if #(
  parameter int DATA_WIDTH = mac_accum_pkg::DATA_WIDTH_DEF,
  parameter int VEC_LENGTH = mac_accum_pkg::VEC_LENGTH_DEF,
  parameter int ACC_WIDTH  = mac_accum_pkg::ACC_WIDTH_DEF,
  parameter int BEAT_W     = mac_accum_pkg::BEAT_W_DEF
);
  logic                                   cmd_valid;
  logic                                   cmd_ready;
  logic [2:0]                             cmd_sel;
  logic [BEAT_W-1:0]                      cmd_beats;
  logic                                   cmd_shift;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_data;
  logic                                   dp_en;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  dp_in;
  logic [2:0]                             dp_sel;
  logic signed [DATA_WIDTH+1:0]           dp_out;
  logic                                   res_valid;
  logic                                   res_ready;
  logic [ACC_WIDTH-1:0]                   res_data;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_beats, cmd_shift, in_valid, in_data, dp_out, res_ready,
    output cmd_ready, in_ready, dp_en, dp_in, dp_sel, res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_beats, cmd_shift, in_valid, in_data, dp_out, res_ready,
    input  cmd_ready, in_ready, dp_en, dp_in, dp_sel, res_valid, res_data
  );
endinterface

// File: rtl/mac_valid_pipe.sv
// Valid-bit delay line tracking beats through the external datapath.
module mac_valid_pipe #(
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  output logic [STAGES:1]   vld_pipe
);
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      for (int i = STAGES; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[1] <= beat;
    end
  end
endmodule

// File: rtl/mac_accum_sequencer.sv
// Job sequencer: feeds beats to an external 2-cycle datapath and accumulates its results.
module mac_accum_sequencer
  import mac_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LENGTH = VEC_LENGTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int BEAT_W     = BEAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  mac_accum_sequencer_if.slave  bus
);
  state_t                state;
  logic [2:0]            cfg_sel;
  logic [BEAT_W-1:0]     cfg_beats;
  logic                  cfg_shift;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [ACC_WIDTH-1:0]  acc;
  logic [PIPE_STAGES:1]  vld_pipe;

  logic                  accept;
  logic                  consume;
  logic                  last_consume;
  logic [ACC_WIDTH-1:0]  dout_ext;
  logic [ACC_WIDTH-1:0]  acc_next;

  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = vld_pipe[PIPE_STAGES];
  // In DRAIN nothing new enters, so the last beat is the one with an empty stage behind it.
  assign last_consume = (state == DRAIN) && consume && !vld_pipe[1];
  assign dout_ext     = {{(ACC_WIDTH-DATA_WIDTH-2){bus.dp_out[DATA_WIDTH+1]}}, bus.dp_out};
  assign acc_next     = (cfg_shift ? {acc[ACC_WIDTH-2:0], 1'b0} : acc) + dout_ext;

  mac_valid_pipe #(.STAGES(PIPE_STAGES)) u_vld_pipe (
    .clk      (clk),
    .reset    (reset),
    .beat     (accept),
    .vld_pipe (vld_pipe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cfg_sel   <= '0;
      cfg_beats <= '0;
      cfg_shift <= 1'b0;
      beat_cnt  <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          cfg_sel   <= bus.cmd_sel;
          cfg_beats <= bus.cmd_beats;
          cfg_shift <= bus.cmd_shift;
          beat_cnt  <= '0;
          acc       <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == cfg_beats) state <= DRAIN;
          end
          if (consume) acc <= acc_next;
        end
        DRAIN: begin
          if (consume) acc <= acc_next;
          if (last_consume) state <= DONE;
        end
        DONE: if (bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake decodes are also forced low while reset is held.
  assign bus.cmd_ready = !reset && (state == IDLE);
  assign bus.in_ready  = !reset && (state == RUN);
  assign bus.dp_en     = !reset && ((state == RUN) || (state == DRAIN));
  assign bus.res_valid = !reset && (state == DONE);
  assign bus.dp_in     = accept ? bus.in_data : '0;
  assign bus.dp_sel    = cfg_sel;
  assign bus.res_data  = acc;
endmodule

// File: tb/tb_mac_accum_sequencer.sv
// Directed bench for mac_accum_sequencer with a 2-cycle lane-0 datapath stub.
module tb_mac_accum_sequencer;
  import mac_accum_pkg::*;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int VL = VEC_LENGTH_DEF;
  localparam int AW = ACC_WIDTH_DEF;
  localparam int BW = BEAT_W_DEF;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mac_accum_sequencer_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .BEAT_W(BW)) bus();

  mac_accum_sequencer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .BEAT_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath stub: result = sign-extended lane 0, two registers deep.
  logic signed [DW+1:0] stub_s1;
  always @(posedge clk) begin
    if (reset) begin
      stub_s1    <= '0;
      bus.dp_out <= '0;
    end else begin
      stub_s1    <= bus.dp_en ? {{2{bus.dp_in[0][DW-1]}}, bus.dp_in[0]} : '0;
      bus.dp_out <= stub_s1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [DW-1:0] v, output lane_vec_t lv);
    lv[0] = v;
    for (int i = 1; i < VL; i++) lv[i] = DW'(24'h0A0A00 + i);
    bus.in_data = lv;
  endtask

  task automatic send_cmd(input logic [2:0] sel, input logic [BW-1:0] beats, input logic shift);
    bus.cmd_sel   = sel;
    bus.cmd_beats = beats;
    bus.cmd_shift = shift;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] v);
    lane_vec_t lv;
    set_lanes(v, lv);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    tick();
    tick();
    checks++;
    if ({bus.cmd_ready, bus.in_ready, bus.res_valid, bus.dp_en} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl got=%b exp=0000", {bus.cmd_ready, bus.in_ready, bus.res_valid, bus.dp_en});
    end
    checks++;
    if (bus.dp_in !== '0 || bus.dp_sel !== 3'd0 || bus.res_data !== '0) begin
      errors++;
      $display("FAIL rst_data dp_in=%h dp_sel=%0d res_data=%h exp=0", bus.dp_in, bus.dp_sel, bus.res_data);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_plain_sum();
    send_cmd(3'd5, BW'(2), 1'b0);
    checks++;
    if ({bus.in_ready, bus.cmd_ready, bus.dp_en} !== 3'b101 || bus.dp_sel !== 3'd5) begin
      errors++;
      $display("FAIL s1_run got=%b sel=%0d exp=101 sel=5", {bus.in_ready, bus.cmd_ready, bus.dp_en}, bus.dp_sel);
    end
    send_beat(DW'(5));
    send_beat(-DW'(2));
    send_beat(DW'(7));
    checks++;
    if ({bus.res_valid, bus.in_ready, bus.dp_en} !== 3'b001) begin
      errors++;
      $display("FAIL s1_drain_n got=%b exp=001", {bus.res_valid, bus.in_ready, bus.dp_en});
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL s1_res_valid_n1 got=%b exp=0", bus.res_valid);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== AW'(10) || bus.dp_en !== 1'b0) begin
      errors++;
      $display("FAIL s1_result valid=%b data=%0d dp_en=%b exp valid=1 data=10 dp_en=0",
               bus.res_valid, bus.res_data, bus.dp_en);
    end
    checks++;
    if (bus.dp_sel !== 3'd5) begin
      errors++;
      $display("FAIL s1_dp_sel_done got=%0d exp=5", bus.dp_sel);
    end
    release_result();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL s1_release valid=%b cmd_ready=%b exp 0 1", bus.res_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_shift();
    bit found;
    send_cmd(3'd2, BW'(2), 1'b1);
    send_beat(DW'(1));
    send_beat(DW'(0));
    send_beat(DW'(1));
    wait_done(found);
    checks++;
    if (!found || bus.res_data !== AW'(5)) begin
      errors++;
      $display("FAIL s2_shift found=%b got=%0d exp=5", found, bus.res_data);
    end
    release_result();
  endtask

  task automatic test_single_hold();
    bit found;
    send_cmd(3'd1, BW'(0), 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL s3_in_ready got=%b exp=1", bus.in_ready);
    end
    send_beat(-DW'(1));
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL s3_one_beat_drain in_ready=%b exp=0", bus.in_ready);
    end
    wait_done(found);
    bus.cmd_valid = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!found || bus.res_valid !== 1'b1 || bus.res_data !== 32'hFFFF_FFFF ||
          bus.cmd_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL s3_hold cyc=%0d valid=%b data=%h cmd_ready=%b in_ready=%b exp 1 ffffffff 0 0",
                 i, bus.res_valid, bus.res_data, bus.cmd_ready, bus.in_ready);
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    release_result();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL s3_idle cmd_ready=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_gaps();
    int        pat[7]  = '{1, 0, 0, 1, 1, 0, 1};
    int        vals[4] = '{2, 3, 4, 6};
    int        k = 0;
    bit        found;
    lane_vec_t lv;
    lane_vec_t exp_in;
    send_cmd(3'd3, BW'(3), 1'b0);
    for (int c = 0; c < 7; c++) begin
      if (pat[c] != 0) begin
        set_lanes(DW'(vals[k]), lv);
        exp_in = lv;
        k++;
      end else begin
        set_lanes(DW'(24'h000123), lv);
        exp_in = '0;
      end
      bus.in_valid = (pat[c] != 0);
      #1;
      checks++;
      if (bus.dp_in !== exp_in) begin
        errors++;
        $display("FAIL s4_dp_in cyc=%0d got=%h exp=%h", c, bus.dp_in, exp_in);
      end
      tick();
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL s4_drain in_ready=%b exp=0", bus.in_ready);
    end
    set_lanes(DW'(100), lv);
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.dp_in !== '0) begin
      errors++;
      $display("FAIL s4_ignored_dp_in got=%h exp=0", bus.dp_in);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_done(found);
    checks++;
    if (!found || bus.res_data !== AW'(15)) begin
      errors++;
      $display("FAIL s4_result found=%b got=%0d exp=15", found, bus.res_data);
    end
    release_result();
  endtask

  task automatic test_reset_abort();
    bit found;
    send_cmd(3'd4, BW'(3), 1'b0);
    send_beat(DW'(10));
    send_beat(DW'(20));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_data !== '0) begin
      errors++;
      $display("FAIL s5_abort cmd_ready=%b valid=%b in_ready=%b data=%0d exp 1 0 0 0",
               bus.cmd_ready, bus.res_valid, bus.in_ready, bus.res_data);
    end
    tick();
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL s5_no_result got=%b exp=0", bus.res_valid);
    end
    send_cmd(3'd0, BW'(0), 1'b0);
    send_beat(DW'(3));
    wait_done(found);
    checks++;
    if (!found || bus.res_data !== AW'(3)) begin
      errors++;
      $display("FAIL s5_new_job found=%b got=%0d exp=3", found, bus.res_data);
    end
    release_result();
  endtask

  task automatic test_max_beats();
    bit found;
    send_cmd(3'd6, BW'(255), 1'b0);
    for (int i = 0; i < 255; i++) send_beat(DW'(1));
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_no_wrap in_ready=%b exp=1", bus.in_ready);
    end
    send_beat(DW'(1));
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL max_drain in_ready=%b exp=0", bus.in_ready);
    end
    wait_done(found);
    checks++;
    if (!found || bus.res_data !== AW'(256)) begin
      errors++;
      $display("FAIL max_result found=%b got=%0d exp=256", found, bus.res_data);
    end
    release_result();
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_beats = '0;
    bus.cmd_shift = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_plain_sum();
    test_shift();
    test_single_hold();
    test_gaps();
    test_reset_abort();
    test_max_beats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
